// File: rtl/decode_stage_q.sv
// RV32I(+M) decode stage: instruction queue between IF and ID, load-use bubbling,
// flush, illegal flagging and a saturating hazard-stall counter feeding the EX register.
module decode_stage_q #(
  parameter int IBUF_DEPTH = 4,
  parameter bit ENABLE_M   = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             if_valid,
  input  logic [31:0]      if_pc,
  input  logic [31:0]      if_instr,
  output logic             if_ready,
  input  logic             ex_ready,
  output logic [4:0]       read_reg1,
  output logic [4:0]       read_reg2,
  input  logic [31:0]      read_data1,
  input  logic [31:0]      read_data2,
  output logic [31:0]      ex_rs1_data,
  output logic [31:0]      ex_rs2_data,
  output logic             ex_valid,
  output logic [31:0]      ex_pc,
  output logic [31:0]      ex_pcp4,
  output logic [31:0]      ex_imm,
  output logic [31:0]      ex_instr,
  output logic [4:0]       ex_rd,
  output logic             ex_reg_write,
  output logic [1:0]       ex_mem_to_reg,
  output logic [1:0]       ex_mem_rw,
  output logic [2:0]       ex_branch,
  output logic [2:0]       ex_alu_class,
  output logic [1:0]       ex_alu_src,
  output logic [4:0]       ex_alu_op,
  output logic             ex_illegal,
  output logic [CNT_W-1:0] hazard_cnt
);
  localparam int PTR_W = $clog2(IBUF_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(IBUF_DEPTH);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [31:0]      q_pc    [IBUF_DEPTH];
  logic [31:0]      q_instr [IBUF_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0]   count;
  logic             empty, push, hazard, vld_p0;
  logic [31:0]      head_pc, head_instr;

  assign empty      = (count == '0);
  assign if_ready   = (count != DEPTH_C);
  assign push       = if_valid && if_ready && !flush;
  assign head_pc    = q_pc[rd_ptr];
  assign head_instr = q_instr[rd_ptr];
  assign read_reg1  = empty ? 5'd0 : head_instr[19:15];
  assign read_reg2  = empty ? 5'd0 : head_instr[24:20];

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]    <= if_pc;
      q_instr[wr_ptr] <= if_instr;
    end
  end

  // ---- p0: combinational decode of the queue head ----
  logic [6:0]  opc_p0, f7_p0;
  logic [2:0]  f3_p0;
  logic [31:0] imm_i_p0, imm_s_p0, imm_b_p0, imm_u_p0, imm_j_p0;
  logic [4:0]  rd_p0, alu_op_p0;
  logic        reg_write_p0, ill_p0, use_rs1_p0, use_rs2_p0;
  logic [1:0]  mem_to_reg_p0, mem_rw_p0, alu_src_p0;
  logic [2:0]  branch_p0, alu_class_p0;
  logic [31:0] imm_p0;

  assign opc_p0   = head_instr[6:0];
  assign f3_p0    = head_instr[14:12];
  assign f7_p0    = head_instr[31:25];
  assign imm_i_p0 = {{20{head_instr[31]}}, head_instr[31:20]};
  assign imm_s_p0 = {{20{head_instr[31]}}, head_instr[31:25], head_instr[11:7]};
  assign imm_b_p0 = {{19{head_instr[31]}}, head_instr[31], head_instr[7],
                     head_instr[30:25], head_instr[11:8], 1'b0};
  assign imm_u_p0 = {head_instr[31:12], 12'd0};
  assign imm_j_p0 = {{11{head_instr[31]}}, head_instr[31], head_instr[19:12],
                     head_instr[20], head_instr[30:21], 1'b0};

  always_comb begin
    rd_p0 = 5'd0; reg_write_p0 = 1'b0; mem_to_reg_p0 = 2'b00; mem_rw_p0 = 2'b00;
    branch_p0 = 3'b000; alu_class_p0 = 3'b000; alu_src_p0 = 2'b00; alu_op_p0 = 5'd0;
    imm_p0 = 32'd0; ill_p0 = 1'b0; use_rs1_p0 = 1'b1; use_rs2_p0 = 1'b0;
    case (opc_p0)
      OPC_LUI: begin
        use_rs1_p0 = 1'b0; rd_p0 = head_instr[11:7]; reg_write_p0 = 1'b1;
        alu_class_p0 = 3'b010; alu_src_p0 = 2'b01; imm_p0 = imm_u_p0;
      end
      OPC_AUIPC: begin
        use_rs1_p0 = 1'b0; rd_p0 = head_instr[11:7]; reg_write_p0 = 1'b1;
        alu_src_p0 = 2'b11; imm_p0 = imm_u_p0;
      end
      OPC_JAL, OPC_JALR: begin
        use_rs1_p0 = (opc_p0 == OPC_JALR); rd_p0 = head_instr[11:7]; reg_write_p0 = 1'b1;
        mem_to_reg_p0 = 2'b10; branch_p0 = 3'b111; alu_class_p0 = 3'b011;
        alu_src_p0 = (opc_p0 == OPC_JALR) ? 2'b01 : 2'b11;
        imm_p0     = (opc_p0 == OPC_JALR) ? imm_i_p0 : imm_j_p0;
      end
      OPC_LOAD: begin
        rd_p0 = head_instr[11:7]; reg_write_p0 = 1'b1; mem_to_reg_p0 = 2'b01;
        mem_rw_p0 = 2'b10; alu_src_p0 = 2'b01; imm_p0 = imm_i_p0; alu_op_p0 = {2'b00, f3_p0};
      end
      OPC_OPIMM: begin
        rd_p0 = head_instr[11:7]; reg_write_p0 = 1'b1; alu_src_p0 = 2'b01; imm_p0 = imm_i_p0;
        alu_op_p0 = {1'b0, (f3_p0 == 3'b101) ? head_instr[30] : 1'b0, f3_p0};
      end
      OPC_BRANCH: begin
        use_rs2_p0 = 1'b1; alu_class_p0 = 3'b001; imm_p0 = imm_b_p0;
        case (f3_p0)
          3'b000:  branch_p0 = 3'b001;
          3'b001:  branch_p0 = 3'b010;
          3'b100:  branch_p0 = 3'b011;
          3'b101:  branch_p0 = 3'b100;
          3'b110:  branch_p0 = 3'b101;
          3'b111:  branch_p0 = 3'b110;
          default: ill_p0 = 1'b1;
        endcase
      end
      OPC_STORE: begin
        use_rs2_p0 = 1'b1; mem_rw_p0 = 2'b01; alu_class_p0 = 3'b100; alu_src_p0 = 2'b01;
        imm_p0 = imm_s_p0; alu_op_p0 = {2'b00, f3_p0};
      end
      OPC_OP: begin
        use_rs2_p0 = 1'b1; rd_p0 = head_instr[11:7]; reg_write_p0 = 1'b1;
        if (f7_p0 == 7'b0000000 || f7_p0 == 7'b0100000)
          alu_op_p0 = {1'b0, head_instr[30], f3_p0};
        else if (ENABLE_M && f7_p0 == 7'b0000001)
          alu_op_p0 = {2'b10, f3_p0};
        else
          ill_p0 = 1'b1;
      end
      default: ill_p0 = 1'b1;
    endcase
    // Illegal entries still travel down the pipe, but must not have side effects.
    if (ill_p0) begin
      rd_p0 = 5'd0; reg_write_p0 = 1'b0; mem_to_reg_p0 = 2'b00; mem_rw_p0 = 2'b00;
      branch_p0 = 3'b000; alu_class_p0 = 3'b000; alu_src_p0 = 2'b00; alu_op_p0 = 5'd0;
      imm_p0 = 32'd0;
    end
    if (rd_p0 == 5'd0) reg_write_p0 = 1'b0;
  end

  assign hazard = !empty && ex_valid && (ex_mem_rw == 2'b10) && (ex_rd != 5'd0) &&
                  ((use_rs1_p0 && head_instr[19:15] == ex_rd) ||
                   (use_rs2_p0 && head_instr[24:20] == ex_rd));
  assign vld_p0 = !empty && ex_ready && !hazard && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0; wr_ptr <= '0; count <= '0;
    end else if (flush) begin
      rd_ptr <= '0; wr_ptr <= '0; count <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (vld_p0) rd_ptr <= rd_ptr + 1'b1;
      case ({push, vld_p0})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---- p1: EX pipeline register ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst || flush) begin
      ex_valid <= 1'b0; ex_pc <= '0; ex_pcp4 <= '0; ex_imm <= '0; ex_instr <= '0;
      ex_rs1_data <= '0; ex_rs2_data <= '0; ex_rd <= '0; ex_reg_write <= 1'b0;
      ex_mem_to_reg <= '0; ex_mem_rw <= '0; ex_branch <= '0; ex_alu_class <= '0;
      ex_alu_src <= '0; ex_alu_op <= '0; ex_illegal <= 1'b0;
      if (!rst) hazard_cnt <= '0;
    end else if (ex_ready) begin
      ex_valid      <= vld_p0;
      ex_pc         <= vld_p0 ? head_pc : '0;
      ex_pcp4       <= vld_p0 ? head_pc + 32'd4 : '0;
      ex_instr      <= vld_p0 ? head_instr : '0;
      ex_imm        <= vld_p0 ? imm_p0 : '0;
      ex_rs1_data   <= vld_p0 ? read_data1 : '0;
      ex_rs2_data   <= vld_p0 ? read_data2 : '0;
      ex_rd         <= vld_p0 ? rd_p0 : '0;
      ex_reg_write  <= vld_p0 && reg_write_p0;
      ex_mem_to_reg <= vld_p0 ? mem_to_reg_p0 : '0;
      ex_mem_rw     <= vld_p0 ? mem_rw_p0 : '0;
      ex_branch     <= vld_p0 ? branch_p0 : '0;
      ex_alu_class  <= vld_p0 ? alu_class_p0 : '0;
      ex_alu_src    <= vld_p0 ? alu_src_p0 : '0;
      ex_alu_op     <= vld_p0 ? alu_op_p0 : '0;
      ex_illegal    <= vld_p0 && ill_p0;
      if (hazard) hazard_cnt <= sat_inc(hazard_cnt);
    end
  end
endmodule

// File: doc/decode_stage_q.md
Name: decode_stage_q

Overview:
- RV32I(+optional M) instruction-decode stage with a parametrised instruction queue between IF and ID, valid/ready handshakes on both sides, built-in load-use hazard bubbling, flush support, illegal-instruction flagging and a hazard-stall counter.
- Sits between the fetch stage and the EX pipeline register.
- Drives the register-file read addresses combinationally from the queue head.

Parameters:
- IBUF_DEPTH, 4, instruction queue entries; power of two, >=2.
- ENABLE_M, 1, 1 = decode opcode 0110011 with funct7=0000001 as M-extension; 0 = flag it illegal.
- CNT_W, 16, width of the saturating hazard-stall counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  branch/jump redirect from EX; kills queue and EX register.
- if_valid  in  1  fetch presents an instruction.
- if_pc  in  32  PC of the fetched instruction.
- if_instr  in  32  fetched instruction.
- if_ready  out  1  queue can accept; equals (count < IBUF_DEPTH), registered state only.
- ex_ready  in  1  EX can accept a new entry; 0 holds the EX register.
- read_reg1, read_reg2  out  5  head instr[19:15], instr[24:20]; 0 when queue empty.
- read_data1, read_data2  in  32  register-file data for the head.
- ex_rs1_data, ex_rs2_data  out  32  registered operand data.
- ex_valid  out  1  EX register holds a real instruction.
- ex_pc, ex_pcp4, ex_imm, ex_instr  out  32  registered PC, PC+4 (mod 2^32), sign-extended immediate, raw instruction.
- ex_rd  out  5  destination register.
- ex_reg_write  out  1  writes rd.
- ex_mem_to_reg  out  2  00 ALU, 01 memory, 10 PC+4.
- ex_mem_rw  out  2  00 none, 10 load, 01 store.
- ex_branch  out  3  000 none, 001 beq, 010 bne, 011 blt, 100 bge, 101 bltu, 110 bgeu, 111 jump.
- ex_alu_class  out  3  000 normal, 001 compare, 010 pass-imm (lui), 011 jump, 100 store.
- ex_alu_src  out  2  bit1 A-select (0 rs1, 1 PC); bit0 B-select (0 rs2, 1 imm).
- ex_alu_op  out  5  {is_m, qual, funct3}.
- ex_illegal  out  1  unrecognised or disabled encoding.
- hazard_cnt  out  CNT_W  count of load-use bubbles inserted; saturates at all-ones.

Behaviour:
- Reset (rst=0, async): queue empty (rd/wr pointers and count 0), ex_valid=0, hazard_cnt=0, every ex_* output 0. if_ready=1 after reset.
- Queue: circular buffer; push when if_valid && if_ready; pop when the pop condition below holds. Push and pop in the same cycle leave count unchanged. Pointers wrap modulo IBUF_DEPTH. No push at full, even if a pop happens that cycle.
- Hazard: asserted when ex_valid && ex_mem_rw==10 && ex_rd!=0 && the head uses a source register equal to ex_rd.
  - rs1 is used by every opcode except LUI, AUIPC, JAL.
  - rs2 is used by R-type, branch and store.
- Pop condition: queue non-empty && ex_ready && !hazard && !flush.
- EX register update, in priority order:
  - flush: ex_valid=0, all control and data outputs 0, queue emptied; a push in the same cycle is discarded.
  - else !ex_ready: hold every ex_* output.
  - else pop: load the decoded head, ex_valid=1.
  - else (hazard or empty): bubble; ex_valid=0, controls 0. If hazard, increment hazard_cnt (saturating).
- Decode, 1-cycle latency from pop to ex_* outputs:
  - LUI: reg_write=1, class=010, imm_U, src=01.
  - AUIPC: reg_write=1, class=000, src=11, imm_U.
  - JAL: reg_write=1, mem_to_reg=10, branch=111, class=011, src=11, imm_J.
  - JALR: as JAL but src=01, imm_I.
  - LOAD: reg_write=1, mem_to_reg=01, mem_rw=10, src=01, imm_I, alu_op={0,0,f3}.
  - OP-IMM: reg_write=1, src=01, imm_I, alu_op={0, f3==101 ? instr[30] : 0, f3}.
  - BRANCH: class=001, src=00, imm_B, branch per funct3 (010/011 funct3 illegal), rd=0.
  - STORE: mem_rw=01, class=100, src=01, imm_S, alu_op={0,0,f3}, rd=0.
  - OP: reg_write=1, src=00, alu_op={0,instr[30],f3}; when ENABLE_M and funct7=0000001, alu_op={1,0,f3}.
- Illegal: any other opcode, or OP with funct7 not in {0000000, 0100000, and 0000001 if ENABLE_M}. The instruction pops normally with ex_valid=1, ex_illegal=1, reg_write=0, mem_rw=00, branch=000; ex_pc and ex_instr are still loaded.
- For non-illegal entries ex_illegal=0.
- ex_rd=0 forces ex_reg_write=0.
- Reset asserted mid-operation clears everything immediately; pending queue contents are lost.

Test Plan:
- Reset, then push `addi x1,x0,5` (0x00500093) at PC 0x100 with ex_ready=1 -> two cycles later: ex_valid=1, ex_rd=1, ex_imm=5, ex_pcp4=0x104, ex_alu_src=01, ex_alu_op=00000.
- `lw x5,0(x2)` followed by `add x6,x5,x3` -> one bubble (ex_valid=0) between them, hazard_cnt=1. The same pair with rd=x0 -> no bubble.
- Hold ex_ready=0 while pushing 5 instructions with IBUF_DEPTH=4 -> if_ready drops after 4 pushes and the EX register holds. Release ex_ready -> instructions emerge in order, one per cycle, across pointer wrap.
- flush asserted with 3 queued instructions and a simultaneous push -> next cycle ex_valid=0, count=0, if_ready=1; a later push decodes normally.
- `mul x3,x1,x2` (0x022081B3): with ENABLE_M=1 -> ex_alu_op=10000, illegal=0; with ENABLE_M=0 -> ex_illegal=1, ex_reg_write=0. Opcode 0x0000007F -> ex_illegal=1.
- `bgeu x1,x2,-8` -> ex_branch=110, ex_imm=0xFFFFFFF8, ex_alu_class=001. Force the hazard 2^CNT_W+3 times -> hazard_cnt saturates at all-ones.
